// File: rtl/truth_table_sweeper.sv
// Walks stim through every N_IN-bit vector, holding each for DWELL cycles, and samples dut_out on the last cycle.
// Sweep completes (2**N_IN)*DWELL edges after start is accepted; there is no backpressure, and start is ignored while busy.
module truth_table_sweeper #(
  parameter int N_IN  = 4,
  parameter int DWELL = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expect_tbl,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        stim,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   captured_tbl,
  output logic [N_IN:0]          mismatch_cnt,
  output logic                   pass
);

  localparam int              NV       = 1 << N_IN;
  localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] STIM_ONE  = 1;
  localparam logic [N_IN:0]   MC_ONE    = 1;
  localparam logic [7:0]      CNT_LAST  = 8'(DWELL - 1);
  localparam logic [7:0]      CNT_ONE   = 8'd1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NV-1:0]     cap_q, cap_d;
  logic [NV-1:0]     exp_q, exp_d;
  logic [N_IN:0]     mcnt_q, mcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      exp_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      exp_q   <= exp_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    exp_d   = exp_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      IDLE, DONE: begin
        // abort outranks start; results from the last sweep stay visible
        if (abort) begin
          state_d = IDLE;
          stim_d  = '0;
          cnt_d   = '0;
        end else if (start) begin
          state_d = DRIVE;
          stim_d  = '0;
          cnt_d   = '0;
          cap_d   = '0;
          mcnt_d  = '0;
          exp_d   = expect_tbl;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          stim_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cap_d[stim_q] = dut_out;
          if (dut_out != exp_q[stim_q]) mcnt_d = mcnt_q + MC_ONE;
          // stim parks on the last vector rather than wrapping
          if (stim_q == STIM_LAST) begin
            state_d = DONE;
          end else begin
            stim_d = stim_q + STIM_ONE;
            cnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stim         = stim_q;
  assign busy         = (state_q == DRIVE);
  assign done         = (state_q == DONE);
  assign captured_tbl = cap_q;
  assign mismatch_cnt = mcnt_q;
  assign pass         = done && (mcnt_q == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (N_IN=4, DWELL=5) with a result scoreboard.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] expect_tbl;
  logic        dut_out;
  logic [3:0]  stim;
  logic        busy;
  logic        done;
  logic [15:0] captured_tbl;
  logic [4:0]  mismatch_cnt;
  logic        pass;

  typedef struct {
    logic [15:0] cap;
    logic [4:0]  mc;
    logic        pass;
  } res_t;

  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  truth_table_sweeper #(.N_IN(4), .DWELL(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .expect_tbl   (expect_tbl),
    .dut_out      (dut_out),
    .stim         (stim),
    .busy         (busy),
    .done         (done),
    .captured_tbl (captured_tbl),
    .mismatch_cnt (mismatch_cnt),
    .pass         (pass)
  );

  // device under test is modelled as "output = lsb of input"
  assign dut_out = stim[0];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predicted result of a full sweep against the current expect_tbl.
  task automatic push_expect();
    res_t        r;
    logic [3:0]  v;
    r.cap = '0;
    for (int i = 0; i < 16; i++) begin
      v        = i[3:0];
      r.cap[i] = v[0];
    end
    r.mc   = 5'($countones(r.cap ^ expect_tbl));
    r.pass = (r.mc == 5'd0);
    sb.push_back(r);
  endtask

  task automatic do_start();
    start = 1'b1;
    push_expect();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_ticks);
    int   n;
    res_t r;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("done_latency", n, exp_ticks);
    if (done) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        chk("captured_tbl", captured_tbl, r.cap);
        chk("mismatch_cnt", mismatch_cnt, r.mc);
        chk("pass", pass, r.pass);
      end
      chk("done_busy", busy, 1'b0);
      chk("done_stim", stim, 4'hF);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stim"}, stim, 4'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass"}, pass, 1'b0);
    chk({tag, "_cap"}, captured_tbl, 16'h0);
    chk({tag, "_mc"}, mismatch_cnt, 5'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    expect_tbl = 16'h0;
    #3;
    chk_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    // Full sweep with matching expectation; expect_tbl is disturbed mid-sweep.
    expect_tbl = 16'hAAAA;
    do_start();
    for (int t = 0; t < 80; t++) begin
      chk("sweep_stim", stim, 32'(t / 5));
      chk("sweep_busy", busy, 1'b1);
      chk("sweep_done", done, 1'b0);
      if (t == 3) expect_tbl = 16'h1234;
      if (t < 79) tick();
    end
    wait_done(1);
    repeat (3) tick();
    chk("done_hold", done, 1'b1);
    chk("done_hold_pass", pass, 1'b1);

    // One deliberate expectation miss on vector 0.
    expect_tbl = 16'hAAAB;
    do_start();
    chk("restart_done_clr", done, 1'b0);
    chk("restart_cap_clr", captured_tbl, 16'h0);
    chk("restart_mc_clr", mismatch_cnt, 5'h0);
    wait_done(80);

    // Abort at the 23rd edge in DRIVE: four vectors sampled.
    do_start();
    repeat (22) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_stim", stim, 4'h0);
    chk("abort_cap", captured_tbl, 16'h000A);
    chk("abort_mc", mismatch_cnt, 5'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 1'b0);
    chk("idle_abort_cap", captured_tbl, 16'h000A);
    chk("idle_abort_mc", mismatch_cnt, 5'd1);

    // start while busy is ignored; start+abort in DONE returns to IDLE.
    expect_tbl = 16'hAAAA;
    do_start();
    repeat (9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(70);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_done", done, 1'b0);
    chk("sa_busy", busy, 1'b0);
    chk("sa_stim", stim, 4'h0);
    chk("sa_cap", captured_tbl, 16'hAAAA);
    chk("sa_pass", pass, 1'b0);

    // Asynchronous reset mid-sweep, then a clean sweep.
    do_start();
    repeat (39) tick();
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    sb.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_stim", stim, 4'h0);
    do_start();
    wait_done(80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter N_IN, default 4, number of stimulus bits; legal range 1..8.
REQ-002 Parameter DWELL, default 5, clock cycles each input vector is held; legal range 2..255.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin a sweep.
REQ-007 abort  input  1  synchronous request to cancel a sweep in progress.
REQ-008 expect_tbl  input  2**N_IN  expected DUT output, bit i = expected response to vector i.
REQ-009 dut_out  input  1  response of the device under test to stim.
REQ-010 stim  output  N_IN  current input vector driven to the device under test.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  high after a sweep completes; held until the next accepted start or abort.
REQ-013 captured_tbl  output  2**N_IN  sampled DUT output, bit i = response to vector i.
REQ-014 mismatch_cnt  output  N_IN+1  count of vectors where the sample differs from expect_tbl.
REQ-015 pass  output  1  equals done AND (mismatch_cnt == 0).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, DRIVE, DONE.
REQ-017 In IDLE or DONE, start=1 SHALL, at that edge:
- enter DRIVE, set stim=0 and dwell counter=0
- clear captured_tbl and mismatch_cnt; clear done
- register expect_tbl internally; later changes to expect_tbl during the sweep SHALL have no effect.
REQ-018 start in DRIVE SHALL be ignored.
REQ-019 In DRIVE, the dwell counter SHALL increment each cycle while below DWELL-1.
REQ-020 On the edge where the counter equals DWELL-1, the block SHALL:
- write dut_out into captured_tbl[stim]
- increment mismatch_cnt if dut_out differs from the registered expect bit[stim]
- if stim == 2**N_IN-1, enter DONE; otherwise increment stim and reset the counter to 0.
REQ-021 stim SHALL hold stable for exactly DWELL cycles per vector and SHALL never wrap inside a sweep.
REQ-022 Latency: if start is accepted at edge k, the final sample and the DONE transition SHALL occur at edge k + (2**N_IN)*DWELL; busy falls and done rises at that same edge.
REQ-023 busy SHALL be 1 exactly when the state is DRIVE.
REQ-024 mismatch_cnt SHALL saturate-free count 0..2**N_IN; its N_IN+1 width SHALL hold the maximum.
REQ-025 abort=1 in DRIVE SHALL, at that edge, enter IDLE with stim=0 and done=0; captured_tbl and mismatch_cnt SHALL retain their partial values.
REQ-026 abort SHALL have priority over start when both are high in the same cycle, in every state.
REQ-027 abort in IDLE SHALL have no effect; abort in DONE SHALL return to IDLE and clear done.
REQ-028 In DONE, stim SHALL hold 2**N_IN-1, and captured_tbl and mismatch_cnt SHALL hold until the next start.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE with all outputs zero: stim, busy, done, pass, captured_tbl, and mismatch_cnt.
REQ-030 Reset asserted mid-sweep SHALL discard the sweep; after release the block SHALL wait in IDLE for start.

Verification
REQ-031 The bench SHALL cover these directed scenarios with N_IN=4 and DWELL=5:
- Full sweep, dut_out = stim[0], expect_tbl=16'hAAAA: done at start edge+80, captured_tbl=16'hAAAA, mismatch_cnt=0, pass=1.
- Same stimulus, expect_tbl=16'hAAAB: mismatch_cnt=1, pass=0, captured_tbl=16'hAAAA.
- Stim stability: each of stim values 0..15 SHALL appear for exactly 5 consecutive cycles, in ascending order.
- Abort after 23 cycles in DRIVE: next edge IDLE, busy=0, done=0, stim=0; captured_tbl[3:0] populated with the four vectors sampled so far.
- start while busy at cycle 10, and start with abort together in DONE: first ignored (done still at edge+80); second results in IDLE with done=0.
- rst_n pulsed low at cycle 40 of a sweep: all outputs 0 asynchronously; a new start then completes normally at +80.
